// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter: round-robin front end that shares one clocked AND unit
// between NREQ requesters. One operation is in flight at a time; the result
// comes back tagged with the ID of the requester that issued it.
module and_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         unit_a,
  output logic [WIDTH-1:0]         unit_b,
  input  logic [WIDTH-1:0]         unit_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   scan_idx;
  logic             accept;

  // Find the first valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Offer the winner a one-hot ready strobe, only while the unit is free.
  always_comb begin
    accept    = (state == IDLE) && grant_found;
    req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  end

  assign busy = (state != IDLE);

  // Sequencer: launch the operands, count out the unit latency, hold the
  // response until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unit_a <= req_a[grant_idx*WIDTH +: WIDTH];
            unit_b <= req_b[grant_idx*WIDTH +: WIDTH];
            rsp_id <= grant_idx;
            ptr    <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
            cnt    <= CW'(LAT);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_data  <= unit_y;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_unit_arbiter.sv
// tb_and_unit_arbiter: directed checks of the AND-unit arbiter, one LAT=1
// instance for arbitration/sequencing and one LAT=3 instance for latency.
module tb_and_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      unit_a, unit_b, unit_y;
  logic                  rsp_valid, rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;

  logic [NREQ-1:0]       req_valid_l3;
  logic [NREQ*WIDTH-1:0] req_a_l3, req_b_l3;
  logic [NREQ-1:0]       req_ready_l3;
  logic [WIDTH-1:0]      unit_a_l3, unit_b_l3, unit_y_l3;
  logic                  rsp_valid_l3, rsp_ready_l3;
  logic [1:0]            rsp_id_l3;
  logic [WIDTH-1:0]      rsp_data_l3;
  logic                  busy_l3;

  and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .unit_a(unit_a), .unit_b(unit_b), .unit_y(unit_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_l3), .req_a(req_a_l3), .req_b(req_b_l3), .req_ready(req_ready_l3),
    .unit_a(unit_a_l3), .unit_b(unit_b_l3), .unit_y(unit_y_l3),
    .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready_l3), .rsp_id(rsp_id_l3),
    .rsp_data(rsp_data_l3), .busy(busy_l3)
  );

  // Model of the shared AND unit: result registered LAT cycles after the operands.
  logic [WIDTH-1:0] y1_q;
  logic [WIDTH-1:0] y3_q [3];
  always @(posedge clk) begin
    y1_q    <= unit_a & unit_b;
    y3_q[0] <= unit_a_l3 & unit_b_l3;
    y3_q[1] <= y3_q[0];
    y3_q[2] <= y3_q[1];
  end
  assign unit_y    = y1_q;
  assign unit_y_l3 = y3_q[2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [6];
  int   order [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_valid[id]            = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ngrant, nrsp, last;

    vecs[0] = '{2, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{0, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{1, 8'hA5, 8'h5A, 8'h00};
    vecs[3] = '{3, 8'hFF, 8'hFF, 8'hFF};
    vecs[4] = '{1, 8'hC3, 8'h81, 8'h81};
    vecs[5] = '{0, 8'h6E, 8'h3B, 8'h2A};
    order   = '{0, 1, 2, 3, 0, 1};

    reset        = 1'b1;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = 1'b1;
    req_valid_l3 = '0;
    req_a_l3     = '0;
    req_b_l3     = '0;
    rsp_ready_l3 = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst busy", busy, 0);
    checkOutput("rst rsp_valid", rsp_valid, 0);
    checkOutput("rst rsp_id", rsp_id, 0);
    checkOutput("rst rsp_data", rsp_data, 0);
    checkOutput("rst unit_a", unit_a, 0);
    checkOutput("rst unit_b", unit_b, 0);
    checkOutput("rst req_ready", req_ready, 0);

    $display("[TB] single-request vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b);
      #1;
      checkOutput("vec req_ready", req_ready, 32'd1 << vecs[i].id);
      tick();
      req_valid = '0;
      #1;
      checkOutput("vec busy T+1", busy, 1);
      checkOutput("vec unit_a", unit_a, vecs[i].a);
      checkOutput("vec unit_b", unit_b, vecs[i].b);
      checkOutput("vec req_ready busy", req_ready, 0);
      tick();
      checkOutput("vec rsp_valid T+2", rsp_valid, 0);
      checkOutput("vec busy T+2", busy, 1);
      tick();
      checkOutput("vec rsp_valid T+3", rsp_valid, 1);
      checkOutput("vec rsp_id", rsp_id, vecs[i].id);
      checkOutput("vec rsp_data", rsp_data, vecs[i].y);
      checkOutput("vec busy T+3", busy, 1);
      tick();
      checkOutput("vec rsp_valid T+4", rsp_valid, 0);
      checkOutput("vec busy T+4", busy, 0);
    end

    $display("[TB] round robin, all requesters");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'hFF, 8'(8'h11 * (i + 1)));
    ngrant = 0;
    nrsp   = 0;
    last   = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_ready != '0) begin
        if (ngrant < 6) checkOutput("rr grant", req_ready, 32'd1 << order[ngrant]);
        if (ngrant > 0) checkOutput("rr spacing", c - last, 4);
        last = c;
        ngrant++;
      end
      tick();
      if (ngrant == 6) req_valid = '0;
      if (rsp_valid) begin
        if (nrsp < 6) begin
          checkOutput("rr rsp_id", rsp_id, order[nrsp]);
          checkOutput("rr rsp_data", rsp_data, 8'(8'h11 * (order[nrsp] + 1)));
        end
        nrsp++;
      end
    end
    checkOutput("rr grant count", ngrant, 6);
    checkOutput("rr rsp count", nrsp, 6);

    $display("[TB] wrap from ptr=2 with requesters 1 and 3");
    req_valid = 4'b1010;
    #1;
    checkOutput("wrap first", req_ready, 4'b1000);
    tick();
    tick();
    tick();
    checkOutput("wrap rsp_id 3", rsp_id, 3);
    checkOutput("wrap rsp_data 3", rsp_data, 8'h44);
    tick();
    #1;
    checkOutput("wrap second", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    checkOutput("wrap rsp_id 1", rsp_id, 1);
    checkOutput("wrap rsp_data 1", rsp_data, 8'h22);
    tick();

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(2, 8'h3C, 8'hF0);
    #1;
    checkOutput("bp grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp rsp_valid", rsp_valid, 1);
      checkOutput("bp rsp_id", rsp_id, 2);
      checkOutput("bp rsp_data", rsp_data, 8'h30);
      checkOutput("bp busy", busy, 1);
      #1;
      checkOutput("bp req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp release rsp_valid", rsp_valid, 1);
    checkOutput("bp release req_ready", req_ready, 0);
    tick();
    checkOutput("bp idle busy", busy, 0);
    checkOutput("bp idle rsp_valid", rsp_valid, 0);
    checkOutput("bp held rsp_data", rsp_data, 8'h30);
    checkOutput("bp held rsp_id", rsp_id, 2);
    #1;
    checkOutput("bp next grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    checkOutput("bp next unit_a", unit_a, 8'hFF);
    checkOutput("bp next unit_b", unit_b, 8'h11);
    tick();
    tick();
    checkOutput("bp next rsp_id", rsp_id, 0);
    checkOutput("bp next rsp_data", rsp_data, 8'h11);
    tick();

    $display("[TB] reset mid-operation");
    applyStimulus(2, 8'h5A, 8'hFF);
    #1;
    checkOutput("abort grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    checkOutput("abort busy T+1", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort rsp_valid", rsp_valid, 0);
    checkOutput("abort unit_a", unit_a, 0);
    checkOutput("abort unit_b", unit_b, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort no rsp", rsp_valid, 0);
    end
    req_valid = 4'b1010;
    #1;
    checkOutput("abort ptr reset grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    checkOutput("abort after rsp_valid", rsp_valid, 1);
    checkOutput("abort after rsp_data", rsp_data, 8'h22);
    tick();

    $display("[TB] LAT=3 instance");
    req_a_l3[0 +: WIDTH] = 8'hAA;
    req_b_l3[0 +: WIDTH] = 8'h0F;
    req_valid_l3         = 4'b0001;
    #1;
    checkOutput("l3 grant", req_ready_l3, 4'b0001);
    tick();
    req_valid_l3 = '0;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("l3 unit_a", unit_a_l3, 8'hAA);
      checkOutput("l3 unit_b", unit_b_l3, 8'h0F);
      checkOutput("l3 rsp_valid low", rsp_valid_l3, 0);
      tick();
    end
    checkOutput("l3 rsp_valid T+5", rsp_valid_l3, 1);
    checkOutput("l3 rsp_data", rsp_data_l3, 8'h0A);
    checkOutput("l3 rsp_id", rsp_id_l3, 0);
    tick();
    checkOutput("l3 idle busy", busy_l3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
